// File: rtl/i2s_rx.sv
// I2S receiver: oversamples LRCLK/BCLK/SD in the i_clk domain.
// Deserializes left-justified MSB-first L/R words and queues each
// complete frame in a small FIFO that is drained through a valid/ready port.
module i2s_rx #(
    parameter int SAMPLE_W   = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_lrclk,
    input  logic                          i_bclk,
    input  logic                          i_sd,
    input  logic                          i_enable,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [SAMPLE_W-1:0]           o_left,
    output logic [SAMPLE_W-1:0]           o_right,
    output logic [$clog2(FIFO_DEPTH):0]   o_level,
    output logic                          o_overflow,
    output logic                          o_frame_err,
    input  logic                          i_clr_flags
);

    localparam int CW = $clog2(SAMPLE_W + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(SAMPLE_W);
    localparam logic [LW-1:0] DEPTH_L  = LW'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_SYNC, S_LEFT, S_RIGHT} state_t;

    // _p0/_p1: two-flop synchronizer, _p2: previous value for edge detection
    logic lrclk_p0, lrclk_p1, lrclk_p2;
    logic bclk_p0, bclk_p1, bclk_p2;
    logic sd_p0, sd_p1, sd_p2;
    logic [1:0] warm;

    logic lr_rise, lr_fall, lr_edge, bclk_rise;
    logic [SAMPLE_W-1:0] sh;
    logic [CW-1:0]       cnt;
    logic [SAMPLE_W-1:0] closed_word;
    logic [SAMPLE_W-1:0] left_hold;

    state_t state, state_nxt;
    logic push, latch_left, capturing;

    logic [2*SAMPLE_W-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          pop, full, push_ok, ovf_set, ferr_set;
    logic [2*SAMPLE_W-1:0] push_word;

    // Synchronize the three external lines with identical delay
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lrclk_p0 <= 1'b0; lrclk_p1 <= 1'b0; lrclk_p2 <= 1'b0;
            bclk_p0  <= 1'b0; bclk_p1  <= 1'b0; bclk_p2  <= 1'b0;
            sd_p0    <= 1'b0; sd_p1    <= 1'b0; sd_p2    <= 1'b0;
        end else begin
            lrclk_p0 <= i_lrclk;  lrclk_p1 <= lrclk_p0; lrclk_p2 <= lrclk_p1;
            bclk_p0  <= i_bclk;   bclk_p1  <= bclk_p0;  bclk_p2  <= bclk_p1;
            sd_p0    <= i_sd;     sd_p1    <= sd_p0;    sd_p2    <= sd_p1;
        end
    end

    // Edge detection is held off until the synchronizer chain holds real
    // input; otherwise a line sitting high at reset release looks like a rise.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)       warm <= 2'd0;
        else if (warm != 2'd3) warm <= warm + 2'd1;
    end

    assign lr_rise   = (warm == 2'd3) &  lrclk_p1 & ~lrclk_p2;
    assign lr_fall   = (warm == 2'd3) & ~lrclk_p1 &  lrclk_p2;
    assign lr_edge   = lr_rise | lr_fall;
    assign bclk_rise = (warm == 2'd3) &  bclk_p1 & ~bclk_p2;

    // Short half-frames are left-justified with zero LSBs
    assign closed_word = sh << (FULL_CNT - cnt);

    // Shift SD in MSB first; an LRCLK edge closes the half before a coincident BCLK bit
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sh  <= '0;
            cnt <= '0;
        end else if (lr_edge) begin
            if (bclk_rise) begin
                sh  <= {{(SAMPLE_W-1){1'b0}}, sd_p1};
                cnt <= CW'(1);
            end else begin
                sh  <= '0;
                cnt <= '0;
            end
        end else if (bclk_rise && cnt != FULL_CNT) begin
            sh  <= {sh[SAMPLE_W-2:0], sd_p1};
            cnt <= cnt + CW'(1);
        end
    end

    // FSM state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= S_SYNC;
        else          state <= state_nxt;
    end

    // FSM next state: frames start on an LRCLK rise, disable forces resync
    always_comb begin
        state_nxt = state;
        if (!i_enable) begin
            state_nxt = S_SYNC;
        end else begin
            unique case (state)
                S_SYNC:  if (lr_rise) state_nxt = S_LEFT;
                S_LEFT:  if (lr_fall) state_nxt = S_RIGHT;
                S_RIGHT: if (lr_rise) state_nxt = S_LEFT;
                default: state_nxt = S_SYNC;
            endcase
        end
    end

    // FSM outputs: latch left at LRCLK fall, push the pair at LRCLK rise
    always_comb begin
        push       = 1'b0;
        latch_left = 1'b0;
        capturing  = 1'b0;
        if (i_enable) begin
            unique case (state)
                S_LEFT: begin
                    capturing  = 1'b1;
                    latch_left = lr_fall;
                end
                S_RIGHT: begin
                    capturing = 1'b1;
                    push      = lr_rise;
                end
                default: ;
            endcase
        end
    end

    // Hold the left word until the right half completes
    always_ff @(posedge i_clk) begin
        if (latch_left) left_hold <= closed_word;
    end

    assign push_word = {left_hold, closed_word};
    assign o_valid   = (o_level != '0);
    assign pop       = o_valid & i_ready;
    assign full      = (o_level == DEPTH_L);
    assign push_ok   = push & (~full | pop);
    assign ovf_set   = push & full & ~pop;
    assign ferr_set  = capturing & ((lr_edge & (cnt != FULL_CNT)) |
                                    (bclk_rise & ~lr_edge & (cnt == FULL_CNT)));

    // FIFO storage write
    always_ff @(posedge i_clk) begin
        if (push_ok) mem[wr_ptr] <= push_word;
    end

    // FIFO pointers and occupancy
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            o_level <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop)     rd_ptr <= rd_ptr + PW'(1);
            unique case ({push_ok, pop})
                2'b10:   o_level <= o_level + LW'(1);
                2'b01:   o_level <= o_level - LW'(1);
                default: o_level <= o_level;
            endcase
        end
    end

    // Registered head: next stored entry on pop, or the pushed pair into an emptying FIFO
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_left  <= '0;
            o_right <= '0;
        end else if (pop) begin
            if (o_level > LW'(1))  {o_left, o_right} <= mem[rd_ptr + PW'(1)];
            else if (push_ok)      {o_left, o_right} <= push_word;
        end else if (push_ok && o_level == '0) begin
            {o_left, o_right} <= push_word;
        end
    end

    // Sticky flags; a new error wins over a simultaneous clear
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_overflow  <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            o_overflow  <= ovf_set  | (o_overflow  & ~i_clr_flags);
            o_frame_err <= ferr_set | (o_frame_err & ~i_clr_flags);
        end
    end

endmodule
